// File: rtl/rv32_pkg.sv
// Shared RV32I decode definitions: opcodes, funct3 codes, ALU operations,
// the decoded control bundle and immediate/ALU-op helper functions.
package rv32_pkg;

  // Major opcodes (instr[6:0])
  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
  localparam logic [6:0] OPC_OP     = 7'b0110011;

  // Branch conditions (funct3 of BRANCH)
  localparam logic [2:0] F3_BEQ  = 3'b000;
  localparam logic [2:0] F3_BNE  = 3'b001;
  localparam logic [2:0] F3_BLT  = 3'b100;
  localparam logic [2:0] F3_BGE  = 3'b101;
  localparam logic [2:0] F3_BLTU = 3'b110;
  localparam logic [2:0] F3_BGEU = 3'b111;

  // Memory access widths (funct3 of LOAD/STORE)
  localparam logic [2:0] F3_MEM_B  = 3'b000;
  localparam logic [2:0] F3_MEM_H  = 3'b001;
  localparam logic [2:0] F3_MEM_W  = 3'b010;
  localparam logic [2:0] F3_MEM_BU = 3'b100;
  localparam logic [2:0] F3_MEM_HU = 3'b101;

  typedef enum logic [3:0] {
    ALU_ADD  = 4'd0,
    ALU_SUB  = 4'd1,
    ALU_SLL  = 4'd2,
    ALU_SLT  = 4'd3,
    ALU_SLTU = 4'd4,
    ALU_XOR  = 4'd5,
    ALU_SRL  = 4'd6,
    ALU_SRA  = 4'd7,
    ALU_OR   = 4'd8,
    ALU_AND  = 4'd9
  } alu_op_t;

  // Single-bit control outputs of the decode stage
  typedef struct packed {
    logic alu_src1_pc;
    logic alu_src2_imm;
    logic mem_read;
    logic mem_write;
    logic reg_write;
    logic branch;
    logic jump;
    logic illegal;
  } ctrl_t;

  function automatic logic [31:0] imm_i(input logic [31:0] instr);
    return {{20{instr[31]}}, instr[31:20]};
  endfunction

  function automatic logic [31:0] imm_s(input logic [31:0] instr);
    return {{20{instr[31]}}, instr[31:25], instr[11:7]};
  endfunction

  function automatic logic [31:0] imm_b(input logic [31:0] instr);
    return {{19{instr[31]}}, instr[31], instr[7], instr[30:25], instr[11:8], 1'b0};
  endfunction

  function automatic logic [31:0] imm_u(input logic [31:0] instr);
    return {instr[31:12], 12'h000};
  endfunction

  function automatic logic [31:0] imm_j(input logic [31:0] instr);
    return {{11{instr[31]}}, instr[31], instr[19:12], instr[20], instr[30:21], 1'b0};
  endfunction

  // alt selects SUB (funct3 000) or SRA (funct3 101); the caller decides
  // when instr[30] is meaningful.
  function automatic alu_op_t alu_decode(input logic [2:0] funct3, input logic alt);
    alu_op_t op;
    case (funct3)
      3'b000:  op = alt ? ALU_SUB : ALU_ADD;
      3'b001:  op = ALU_SLL;
      3'b010:  op = ALU_SLT;
      3'b011:  op = ALU_SLTU;
      3'b100:  op = ALU_XOR;
      3'b101:  op = alt ? ALU_SRA : ALU_SRL;
      3'b110:  op = ALU_OR;
      default: op = ALU_AND;
    endcase
    return op;
  endfunction

endpackage

// File: rtl/rv32_regs.sv
// 32x32 register file: two combinational read ports, one write port.
// x0 reads as zero and is never written. Contents are not reset.
module rv32_regs #(
  parameter int REG_BYPASS = 1
) (
  input  logic        clk,
  input  logic [4:0]  rs1_idx,
  input  logic [4:0]  rs2_idx,
  output logic [31:0] rs1_data,
  output logic [31:0] rs2_data,
  input  logic        wr_en,
  input  logic [4:0]  wr_idx,
  input  logic [31:0] wr_data
);

  logic [31:0] regs_q [32];

  // Write port: x0 stays unwritten so it never holds anything but don't-care
  always_ff @(posedge clk) begin
    if (wr_en && (wr_idx != 5'd0)) begin
      regs_q[wr_idx] <= wr_data;
    end
  end

  // Read ports: x0 forced to zero; same-cycle writeback optionally forwarded
  always_comb begin
    rs1_data = 32'h0;
    rs2_data = 32'h0;
    if (rs1_idx != 5'd0) begin
      if ((REG_BYPASS != 0) && wr_en && (wr_idx == rs1_idx)) rs1_data = wr_data;
      else                                                  rs1_data = regs_q[rs1_idx];
    end
    if (rs2_idx != 5'd0) begin
      if ((REG_BYPASS != 0) && wr_en && (wr_idx == rs2_idx)) rs2_data = wr_data;
      else                                                  rs2_data = regs_q[rs2_idx];
    end
  end

endmodule

// File: rtl/rv32_decode.sv
// RV32I decode stage: combinational decode of instr_in plus register file
// read, captured into one output register bank (one-cycle latency).
// flush clears valid and the control bits; stall holds the whole bank.
module rv32_decode
  import rv32_pkg::*;
#(
  parameter int REG_BYPASS = 1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [31:0] pc_in,
  input  logic [31:0] instr_in,
  input  logic        stall_in,
  input  logic        flush_in,
  input  logic        rd_write_in,
  input  logic [4:0]  rd_in,
  input  logic [31:0] rd_value_in,
  output logic        valid_out,
  output logic [31:0] pc_out,
  output logic [4:0]  rs1_out,
  output logic [4:0]  rs2_out,
  output logic [4:0]  rd_out,
  output logic [31:0] rs1_value_out,
  output logic [31:0] rs2_value_out,
  output logic [31:0] imm_out,
  output alu_op_t     alu_op_out,
  output logic        alu_src1_pc_out,
  output logic        alu_src2_imm_out,
  output logic        mem_read_out,
  output logic        mem_write_out,
  output logic        reg_write_out,
  output logic        branch_out,
  output logic        jump_out,
  output logic        illegal_out,
  output logic [2:0]  mem_width_out,
  output logic [2:0]  branch_cond_out
);

  logic [6:0]  opcode;
  logic [2:0]  funct3;
  ctrl_t       dec_ctrl;
  alu_op_t     dec_alu_op;
  logic [31:0] dec_imm;
  logic [4:0]  dec_rs1;
  logic [4:0]  dec_rs2;
  logic [4:0]  dec_rd;
  logic [31:0] rf_rs1_data;
  logic [31:0] rf_rs2_data;

  logic        valid_d,     valid_q;
  logic [31:0] pc_d,        pc_q;
  logic [4:0]  rs1_d,       rs1_q;
  logic [4:0]  rs2_d,       rs2_q;
  logic [4:0]  rd_d,        rd_q;
  logic [31:0] rs1_value_d, rs1_value_q;
  logic [31:0] rs2_value_d, rs2_value_q;
  logic [31:0] imm_d,       imm_q;
  alu_op_t     alu_op_d,    alu_op_q;
  ctrl_t       ctrl_d,      ctrl_q;
  logic [2:0]  funct3_d,    funct3_q;

  assign opcode = instr_in[6:0];
  assign funct3 = instr_in[14:12];

  // Reads use the decoded indices so a LUI (rs1 forced to x0) reads zero
  rv32_regs #(
    .REG_BYPASS (REG_BYPASS)
  ) u_regs (
    .clk      (clk),
    .rs1_idx  (dec_rs1),
    .rs2_idx  (dec_rs2),
    .rs1_data (rf_rs1_data),
    .rs2_data (rf_rs2_data),
    .wr_en    (rd_write_in),
    .wr_idx   (rd_in),
    .wr_data  (rd_value_in)
  );

  // Instruction decode: control bits, ALU op, immediate and register indices
  always_comb begin
    dec_ctrl   = '0;
    dec_alu_op = ALU_ADD;
    dec_imm    = 32'h0;
    dec_rd     = instr_in[11:7];
    dec_rs1    = instr_in[19:15];
    dec_rs2    = instr_in[24:20];
    if (instr_in[1:0] != 2'b11) begin
      dec_ctrl.illegal = 1'b1;
    end else begin
      case (opcode)
        OPC_LUI: begin
          dec_rs1               = 5'd0;
          dec_imm               = imm_u(instr_in);
          dec_ctrl.alu_src2_imm = 1'b1;
          dec_ctrl.reg_write    = 1'b1;
        end
        OPC_AUIPC: begin
          dec_imm               = imm_u(instr_in);
          dec_ctrl.alu_src1_pc  = 1'b1;
          dec_ctrl.alu_src2_imm = 1'b1;
          dec_ctrl.reg_write    = 1'b1;
        end
        OPC_JAL: begin
          dec_imm               = imm_j(instr_in);
          dec_ctrl.alu_src1_pc  = 1'b1;
          dec_ctrl.alu_src2_imm = 1'b1;
          dec_ctrl.reg_write    = 1'b1;
          dec_ctrl.jump         = 1'b1;
        end
        OPC_JALR: begin
          dec_imm               = imm_i(instr_in);
          dec_ctrl.alu_src2_imm = 1'b1;
          dec_ctrl.reg_write    = 1'b1;
          dec_ctrl.jump         = 1'b1;
        end
        OPC_BRANCH: begin
          // ALU computes the target pc+imm; execute compares rs1/rs2 itself
          dec_imm               = imm_b(instr_in);
          dec_ctrl.alu_src1_pc  = 1'b1;
          dec_ctrl.alu_src2_imm = 1'b1;
          dec_ctrl.branch       = 1'b1;
        end
        OPC_LOAD: begin
          dec_imm               = imm_i(instr_in);
          dec_ctrl.alu_src2_imm = 1'b1;
          dec_ctrl.mem_read     = 1'b1;
          dec_ctrl.reg_write    = 1'b1;
        end
        OPC_STORE: begin
          dec_imm               = imm_s(instr_in);
          dec_ctrl.alu_src2_imm = 1'b1;
          dec_ctrl.mem_write    = 1'b1;
        end
        OPC_OP_IMM: begin
          // instr[30] is part of the immediate except on SRLI/SRAI
          dec_imm               = imm_i(instr_in);
          dec_alu_op            = alu_decode(funct3, instr_in[30] && (funct3 == 3'b101));
          dec_ctrl.alu_src2_imm = 1'b1;
          dec_ctrl.reg_write    = 1'b1;
        end
        OPC_OP: begin
          dec_alu_op         = alu_decode(funct3, instr_in[30]);
          dec_ctrl.reg_write = 1'b1;
        end
        default: begin
          dec_ctrl.illegal = 1'b1;
        end
      endcase
    end
  end

  // Output bank next state: flush beats stall, stall holds everything
  always_comb begin
    valid_d     = valid_q;
    pc_d        = pc_q;
    rs1_d       = rs1_q;
    rs2_d       = rs2_q;
    rd_d        = rd_q;
    rs1_value_d = rs1_value_q;
    rs2_value_d = rs2_value_q;
    imm_d       = imm_q;
    alu_op_d    = alu_op_q;
    ctrl_d      = ctrl_q;
    funct3_d    = funct3_q;
    if (flush_in) begin
      valid_d = 1'b0;
      ctrl_d  = '0;
    end else if (!stall_in) begin
      valid_d     = 1'b1;
      pc_d        = pc_in;
      rs1_d       = dec_rs1;
      rs2_d       = dec_rs2;
      rd_d        = dec_rd;
      rs1_value_d = rf_rs1_data;
      rs2_value_d = rf_rs2_data;
      imm_d       = dec_imm;
      alu_op_d    = dec_alu_op;
      ctrl_d      = dec_ctrl;
      funct3_d    = funct3;
    end
  end

  // Output register bank with asynchronous clear
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q     <= 1'b0;
      pc_q        <= 32'h0;
      rs1_q       <= 5'd0;
      rs2_q       <= 5'd0;
      rd_q        <= 5'd0;
      rs1_value_q <= 32'h0;
      rs2_value_q <= 32'h0;
      imm_q       <= 32'h0;
      alu_op_q    <= ALU_ADD;
      ctrl_q      <= '0;
      funct3_q    <= 3'b000;
    end else begin
      valid_q     <= valid_d;
      pc_q        <= pc_d;
      rs1_q       <= rs1_d;
      rs2_q       <= rs2_d;
      rd_q        <= rd_d;
      rs1_value_q <= rs1_value_d;
      rs2_value_q <= rs2_value_d;
      imm_q       <= imm_d;
      alu_op_q    <= alu_op_d;
      ctrl_q      <= ctrl_d;
      funct3_q    <= funct3_d;
    end
  end

  assign valid_out        = valid_q;
  assign pc_out           = pc_q;
  assign rs1_out          = rs1_q;
  assign rs2_out          = rs2_q;
  assign rd_out           = rd_q;
  assign rs1_value_out    = rs1_value_q;
  assign rs2_value_out    = rs2_value_q;
  assign imm_out          = imm_q;
  assign alu_op_out       = alu_op_q;
  assign alu_src1_pc_out  = ctrl_q.alu_src1_pc;
  assign alu_src2_imm_out = ctrl_q.alu_src2_imm;
  assign mem_read_out     = ctrl_q.mem_read;
  assign mem_write_out    = ctrl_q.mem_write;
  assign reg_write_out    = ctrl_q.reg_write;
  assign branch_out       = ctrl_q.branch;
  assign jump_out         = ctrl_q.jump;
  assign illegal_out      = ctrl_q.illegal;
  assign mem_width_out    = funct3_q;
  assign branch_cond_out  = funct3_q;

endmodule

// File: doc/rv32_decode.md
RV32_DECODE -- requirements
Module: rv32_decode

Interface
REQ-001 Parameter: REG_BYPASS, default 1, meaning: same-cycle writeback is forwarded to register reads.
REQ-002 The block SHALL use one clock; reset is asynchronous and active-low. Ports clk and rst_n.
REQ-003 clk  in  1  rising-edge clock for all state.
REQ-004 rst_n  in  1  asynchronous active-low reset.
REQ-005 pc_in  in  32  PC of the instruction on instr_in, one cycle after fetch.
REQ-006 instr_in  in  32  fetched instruction word.
REQ-007 stall_in  in  1  hold all output registers.
REQ-008 flush_in  in  1  branch taken; discard the instruction being decoded.
REQ-009 rd_write_in / rd_in / rd_value_in  in  1/5/32  writeback port to the register file.
REQ-010 valid_out  out  1  output bundle holds a live instruction.
REQ-011 pc_out  out  32  PC of the decoded instruction.
REQ-012 rs1_out, rs2_out, rd_out  out  5 each  register indices.
REQ-013 rs1_value_out, rs2_value_out  out  32 each  register file read data.
REQ-014 imm_out  out  32  sign-extended immediate.
REQ-015 alu_op_out  out  alu_op_t  ALU operation.
REQ-016 Single-bit control outputs: alu_src1_pc_out, alu_src2_imm_out, mem_read_out, mem_write_out, reg_write_out, branch_out, jump_out, illegal_out.
REQ-017 Width outputs: mem_width_out (3), branch_cond_out (3); both carry funct3 verbatim.

Function
REQ-018 Latency SHALL be one cycle: inputs sampled at edge N appear on the outputs after edge N.
REQ-019 Immediate formats SHALL follow RV32I: I, S, B, U, J. B and J immediates have bit 0 = 0. U immediate is instr[31:12] followed by 12 zero bits.
REQ-020 Decoded opcodes: LUI, AUIPC, JAL, JALR, BRANCH, LOAD, STORE, OP-IMM, OP. Any other opcode, or instr[1:0] != 2'b11, SHALL set illegal_out=1, valid_out=1 and all other control bits to 0.
REQ-021 OP/OP-IMM SHALL map funct3/funct7[5] to alu_op_t. The SUB/SRA bit is honoured for OP only, and for OP-IMM shifts only.
REQ-022 LUI: rs1 forced to 0, alu_src2_imm=1, op ADD.
REQ-023 AUIPC, JAL, BRANCH: alu_src1_pc=1.
REQ-024 JAL/JALR: jump=1, reg_write=1.
REQ-025 Register file: 32x32. x0 SHALL always read 0, and writes to x0 are ignored. Writes occur on the clk rising edge.
REQ-026 With REG_BYPASS=1, a read whose index equals rd_in, while rd_write_in=1 and rd_in!=0, SHALL return rd_value_in in the same cycle.
REQ-027 Register file reads use instr_in fields combinationally, and the results are registered into rs*_value_out.
REQ-028 flush_in=1 SHALL load valid_out=0, and all control bits and illegal_out=0, at the next edge.
REQ-029 flush_in SHALL take priority over stall_in.
REQ-030 stall_in=1 (no flush) SHALL hold every output register unchanged.
REQ-031 Register file writes SHALL proceed regardless of stall_in and flush_in.
REQ-032 Held rs*_value_out SHALL NOT refresh during a stall; the hazard unit owns forwarding.

Reset
REQ-033 On rst_n low, outputs SHALL asynchronously clear: valid_out=0, all control bits=0, pc_out=0, imm_out=0, indices=0, values=0.
REQ-034 Register file contents SHALL NOT be reset; x0 still reads 0.
REQ-035 Reset asserted mid-stall SHALL clear the outputs. The first valid_out=1 SHALL appear one edge after rst_n rises, provided flush_in=0.

Structure
REQ-036 alu_op_t, opcode localparams and the funct3 branch/width codes SHALL reside in package rv32_pkg, which is shared with execute.
REQ-037 The register file SHALL be sub-module rv32_regs: 2 read ports, 1 write port, REG_BYPASS parameter.

Verification
REQ-038 Input 0x00500093 (addi x1,x0,5) -> next cycle: valid=1, rd=1, rs1=0, imm=0x00000005, alu_op=ADD, alu_src2_imm=1, reg_write=1.
REQ-039 Input 0xFE000EE3 (beq x0,x0,-4) -> imm=0xFFFFFFFC, branch=1, branch_cond=0, alu_src1_pc=1, reg_write=0.
REQ-040 Input 0x123452B7 (lui x5,0x12345) -> imm=0x12345000, rd=5, rs1=0, reg_write=1.
REQ-041 Write x3=0xDEADBEEF in the same cycle as decoding add x4,x3,x0 -> rs1_value=0xDEADBEEF. Write to x0=0x1 -> later reads of x0 return 0.
REQ-042 stall_in=1 for 3 cycles -> outputs constant. Assert flush_in and stall_in together -> valid=0 next cycle.
REQ-043 Input 0x0000000F, and input 0xFFFFFFFF -> illegal_out=1 and all other control bits=0. Reset pulse mid-stream -> all outputs 0 immediately.
